// File: rtl/uart_rx_timing_ctrl.sv
// rtl/uart_rx_timing_ctrl.sv - UART receive timing/control: synchronizer, start qualification, bit-centre strobes, stop check
//
// Purpose: synchronizes the raw serial line, finds the start bit, issues one
// shift_strobe at each bit centre for a downstream (DATA_BITS+1)-bit shift
// register, then inspects the returned stop bit and either pulses
// load_buffer or raises framing_error.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   serial_in     in   raw asynchronous serial line (idles high)
//   stop_bit      in   MSB of the downstream shift register
//   serial_sync   out  two-flop synchronized line (feeds the shift register)
//   shift_strobe  out  one-cycle pulse at every bit centre
//   load_buffer   out  one-cycle pulse, frame received with a good stop bit
//   framing_error out  level, last frame had stop bit 0; cleared by next start
//   busy          out  high whenever the controller is not idle
//
// Build option: define UART_RX_FALSE_START_CHK_EN to re-sample the line at the
// start-bit centre and drop glitches; otherwise every start edge runs a frame.

module uart_rx_timing_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic stop_bit,
    output logic serial_sync,
    output logic shift_strobe,
    output logic load_buffer,
    output logic framing_error,
    output logic busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 2);

    localparam logic [CW-1:0] HALF_LAST    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST     = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] LAST_BIT_IDX = BW'(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_CHK = 2'd1,
        RECV      = 2'd2,
        STOP_CHK  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   clk_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            sync_meta;
    logic            sync_hist;
    logic            start_edge;
    logic            start_ok;
    logic            bit_end;
    logic            strobe_nxt;
    logic            load_nxt;
    logic            fe_nxt;
    logic            busy_nxt;

    // Synchronizer and edge history reset high so a reset never looks like a start.
    // The history flop runs in every state so a start right after a stop is caught.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta   <= 1'b1;
            serial_sync <= 1'b1;
            sync_hist   <= 1'b1;
        end else begin
            sync_meta   <= serial_in;
            serial_sync <= sync_meta;
            sync_hist   <= serial_sync;
        end
    end

    assign start_edge = !serial_sync && sync_hist;
    assign bit_end    = (clk_cnt == BIT_LAST);

`ifdef UART_RX_FALSE_START_CHK_EN
    assign start_ok = !serial_sync;
`else
    assign start_ok = 1'b1;
`endif

    // State register plus the bit-time and bit counters it steers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                START_CHK: clk_cnt <= (clk_cnt == HALF_LAST) ? '0 : clk_cnt + 1'b1;
                RECV: begin
                    clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = START_CHK;
                end
            end
            START_CHK: begin
                if (clk_cnt == HALF_LAST) begin
                    state_nxt = start_ok ? RECV : IDLE;
                end
            end
            RECV: begin
                if (bit_end && (bit_cnt == LAST_BIT_IDX)) begin
                    state_nxt = STOP_CHK;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs. The strobe is decided one count
    // early so the registered pulse lines up with the counter's last value.
    always_comb begin
        strobe_nxt = (state == RECV) && (clk_cnt == PRE_LAST);
        load_nxt   = (state == STOP_CHK) && stop_bit;
        fe_nxt     = framing_error;
        if ((state == IDLE) && start_edge) begin
            fe_nxt = 1'b0;
        end else if ((state == STOP_CHK) && !stop_bit) begin
            fe_nxt = 1'b1;
        end
        busy_nxt   = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_strobe  <= 1'b0;
            load_buffer   <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            shift_strobe  <= strobe_nxt;
            load_buffer   <= load_nxt;
            framing_error <= fe_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_timing_ctrl.sv
// tb/tb_uart_rx_timing_ctrl.sv - self-checking bench for uart_rx_timing_ctrl

module tb_uart_rx_timing_ctrl;

    localparam int C = 10;
    localparam int D = 8;
    localparam int H = C / 2;
`ifdef UART_RX_FALSE_START_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;
    logic stop_bit;
    logic serial_sync;
    logic shift_strobe;
    logic load_buffer;
    logic framing_error;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [8:0] sr = '0;

    always #5 clk = ~clk;

    uart_rx_timing_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clk(clk),
        .rst(rst),
        .serial_in(serial_in),
        .stop_bit(stop_bit),
        .serial_sync(serial_sync),
        .shift_strobe(shift_strobe),
        .load_buffer(load_buffer),
        .framing_error(framing_error),
        .busy(busy)
    );

    // Downstream 9-bit shift register emulation.
    assign stop_bit = sr[8];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (shift_strobe) sr <= {serial_sync, sr[8:1]};
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int qat(int q[$], int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Line history: value of serial_in in each cycle, forced high around a reset
    // because the synchronizer flops are reset high.
    bit eff [0:4095];

    function automatic bit sync_at(int c);
        if (c < 2) return 1'b1;
        return eff[c-2];
    endfunction

    // Frame-level model: a start edge at cycle t0 fixes the whole schedule.
    bit m_valid = 1'b0;
    bit m_active = 1'b0;
    bit m_acc = 1'b0;
    bit m_stop = 1'b0;
    bit m_fe = 1'b0;
    int m_t0 = 0;
    int m_load_at = -1;
    int m_fe_set_at = -1;
    int m_fe_clr_at = -1;
    bit prev_rst = 1'b0;

    // Logs of observed behaviour for the hand-computed expectations.
    int strobe_log[$];
    int load_log[$];
    int load_data[$];
    int busy_cnt = 0;
    int fe_rise_at = -1;
    int fe_fall_at = -1;
    logic fe_prev = 1'b0;

    always @(negedge clk) begin
        int c;
        int k;
        bit s_now;
        bit s_prev;
        bit e_busy;
        bit e_strobe;
        bit e_load;
        c = cyc;
        if (c < 4096) begin
            eff[c] = serial_in;
            if (rst) begin
                eff[c] = 1'b1;
                if (c > 0) eff[c-1] = 1'b1;
            end
            s_now  = sync_at(c);
            s_prev = sync_at(c - 1);

            if (prev_rst) begin
                m_valid = 1'b1;
                m_active = 1'b0;
                m_fe = 1'b0;
                m_load_at = -1;
                m_fe_set_at = -1;
                m_fe_clr_at = -1;
            end else begin
                if (c == m_fe_clr_at) m_fe = 1'b0;
                if (c == m_fe_set_at) m_fe = 1'b1;
            end

            k        = c - m_t0 - H;
            e_busy   = m_active && (c > m_t0);
            e_strobe = m_active && m_acc && (k > 0) && (k % C == 0) && (k / C <= D + 1);
            e_load   = (c == m_load_at);

            if (m_valid) begin
                check("serial_sync", serial_sync, s_now);
                check("shift_strobe", shift_strobe, e_strobe);
                check("load_buffer", load_buffer, e_load);
                check("framing_error", framing_error, m_fe);
                check("busy", busy, e_busy);
                if (shift_strobe === 1'b1) strobe_log.push_back(c);
                if (load_buffer === 1'b1) begin
                    load_log.push_back(c);
                    load_data.push_back(int'(sr[7:0]));
                end
                if (busy === 1'b1) busy_cnt++;
                if (framing_error === 1'b1 && fe_prev === 1'b0) fe_rise_at = c;
                if (framing_error === 1'b0 && fe_prev === 1'b1) fe_fall_at = c;
                fe_prev = framing_error;
            end

            if (!m_active) begin
                if (!s_now && s_prev) begin
                    m_active = 1'b1;
                    m_t0 = c;
                    m_acc = 1'b0;
                    m_fe_clr_at = c + 1;
                end
            end else begin
                if (c == m_t0 + H) begin
                    m_acc = CHK_EN ? !s_now : 1'b1;
                    if (!m_acc) m_active = 1'b0;
                end
                if (m_active && c == m_t0 + H + (D + 1) * C) m_stop = s_now;
                if (m_active && c == m_t0 + H + (D + 1) * C + 1) begin
                    if (m_stop) m_load_at = c + 1;
                    else m_fe_set_at = c + 1;
                    m_active = 1'b0;
                end
            end
            prev_rst = rst;
        end
    end

    task automatic hold(bit v, int n);
        serial_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(logic [7:0] d, bit stop);
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(d[i], C);
        hold(stop, C);
    endtask

    task automatic clear_logs();
        strobe_log.delete();
        load_log.delete();
        load_data.delete();
        busy_cnt = 0;
        fe_rise_at = -1;
        fe_fall_at = -1;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int ts;
        rst = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset serial_sync", serial_sync, 1);
        check("reset shift_strobe", shift_strobe, 0);
        check("reset load_buffer", load_buffer, 0);
        check("reset framing_error", framing_error, 0);
        check("reset busy", busy, 0);
        hold(1'b1, 10);

        // Good frame 0xA5.
        clear_logs();
        ts = cyc;
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 10);
        check("a5 strobe count", strobe_log.size(), 9);
        check("a5 first strobe", qat(strobe_log, 0) - ts - 2, 15);
        check("a5 second strobe", qat(strobe_log, 1) - ts - 2, 25);
        check("a5 last strobe", qat(strobe_log, 8) - ts - 2, 95);
        check("a5 load count", load_log.size(), 1);
        check("a5 load cycle", qat(load_log, 0) - ts - 2, 97);
        check("a5 data", qat(load_data, 0), 32'hA5);
        check("a5 no framing error", framing_error, 0);

        // Same frame, bad stop bit.
        clear_logs();
        ts = cyc;
        send_frame(8'hA5, 1'b0);
        hold(1'b1, 10);
        check("bad stop load count", load_log.size(), 0);
        check("bad stop fe rise", fe_rise_at - ts - 2, 97);
        check("bad stop fe level", framing_error, 1);

        // Next start edge clears the flag one cycle after the edge.
        clear_logs();
        ts = cyc;
        send_frame(8'h3C, 1'b1);
        hold(1'b1, 10);
        check("fe clear cycle", fe_fall_at - ts - 2, 1);
        check("3c data", qat(load_data, 0), 32'h3C);

        // Three-cycle glitch.
        clear_logs();
        hold(1'b0, 3);
        hold(1'b1, 130);
        check("glitch strobes", strobe_log.size(), CHK_EN ? 0 : 9);
        check("glitch busy cycles", busy_cnt, CHK_EN ? 5 : 96);
        check("glitch loads", load_log.size(), CHK_EN ? 0 : 1);
        check("glitch fe", framing_error, 0);

        // Back-to-back frames.
        clear_logs();
        ts = cyc;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 10);
        check("b2b load count", load_log.size(), 2);
        check("b2b first load", qat(load_log, 0) - ts - 2, 97);
        check("b2b spacing", qat(load_log, 1) - qat(load_log, 0), 100);
        check("b2b data0", qat(load_data, 0), 32'h00);
        check("b2b data1", qat(load_data, 1), 32'hFF);

        // Reset one cycle after the 4th strobe; line stays high afterwards.
        clear_logs();
        ts = cyc;
        fork
            send_frame(8'hF8, 1'b1);
            begin
                repeat (48) begin
                    @(posedge clk);
                    #1;
                end
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check("abort busy", busy, 0);
                check("abort strobe", shift_strobe, 0);
                check("abort load", load_buffer, 0);
                check("abort fe", framing_error, 0);
            end
        join
        hold(1'b1, 20);
        check("abort strobe count", strobe_log.size(), 4);
        check("abort loads", load_log.size(), 0);

        clear_logs();
        ts = cyc;
        send_frame(8'h81, 1'b1);
        hold(1'b1, 10);
        check("post reset load count", load_log.size(), 1);
        check("post reset load cycle", qat(load_log, 0) - ts - 2, 97);
        check("post reset data", qat(load_data, 0), 32'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
